// File: rtl/decode_execute_stage.sv
// Decode/Execute pipeline register for the scalar+vector CPU.
// Holds control, operands and addresses; forwards scalar operands and drives the 8-bit scalar and 16-lane vector ALUs.
module decode_execute_stage (
  input  logic          clk,
  input  logic          reset,
  input  logic [19:0]   nop_mux_output_in,
  input  logic [15:0]   srcA_in,
  input  logic [15:0]   srcB_in,
  input  logic [127:0]  srcA_vector_in,
  input  logic [127:0]  srcB_vector_in,
  input  logic [4:0]    rs1_decode,
  input  logic [4:0]    rs2_decode,
  input  logic [4:0]    rd_decode,
  input  logic [2:0]    select_forward_mux_A,
  input  logic [2:0]    select_forward_mux_B,
  input  logic [15:0]   writeback_data,
  input  logic [7:0]    alu_result_memory,
  output logic          wre_execute,
  output logic          vector_wre_execute,
  output logic          write_memory_enable_a_execute,
  output logic          write_memory_enable_b_execute,
  output logic          load_instruction,
  output logic [1:0]    select_writeback_data_mux_execute,
  output logic [1:0]    select_writeback_vector_data_mux_execute,
  output logic [4:0]    aluOp_execute,
  output logic [4:0]    aluVectorOp_execute,
  output logic [15:0]   srcA_out,
  output logic [15:0]   srcB_out,
  output logic [15:0]   alu_src_A,
  output logic [15:0]   alu_src_B,
  output logic [127:0]  srcA_vector_out,
  output logic [127:0]  srcB_vector_out,
  output logic [4:0]    rs1_execute,
  output logic [4:0]    rs2_execute,
  output logic [4:0]    rd_execute,
  output logic [7:0]    alu_result_execute,
  output logic [127:0]  alu_vector_result_execute
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_MUL  = 5'd7;
  localparam logic [4:0] OP_PASA = 5'd8;
  localparam logic [4:0] OP_PASB = 5'd9;

  localparam logic [2:0] FWD_WB  = 3'd1;
  localparam logic [2:0] FWD_MEM = 3'd2;

  // Bit 0 of the control word is reserved and deliberately dropped.
  logic unused_reserved_bit;
  assign unused_reserved_bit = nop_mux_output_in[0];

  // Shared 8-bit ALU used by the scalar path and by every vector lane.
  function automatic logic [7:0] alu8(
    input logic [4:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[2:0];
      OP_SRL:  r = a >> b[2:0];
      OP_MUL:  r = a * b;
      OP_PASA: r = a;
      OP_PASB: r = b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Unlisted select codes fall back to the registered operand.
  function automatic logic [15:0] fwd_mux(
    input logic [2:0]  sel,
    input logic [15:0] reg_val,
    input logic [15:0] wb_val,
    input logic [7:0]  mem_val
  );
    logic [15:0] r;
    case (sel)
      FWD_WB:  r = wb_val;
      FWD_MEM: r = {8'h00, mem_val};
      default: r = reg_val;
    endcase
    return r;
  endfunction

  // Pipeline register: control fields, operands and addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wre_execute                              <= 1'b0;
      vector_wre_execute                       <= 1'b0;
      write_memory_enable_a_execute            <= 1'b0;
      write_memory_enable_b_execute            <= 1'b0;
      select_writeback_data_mux_execute        <= 2'b00;
      select_writeback_vector_data_mux_execute <= 2'b00;
      aluOp_execute                            <= 5'd0;
      aluVectorOp_execute                      <= 5'd0;
      load_instruction                         <= 1'b0;
      srcA_out                                 <= 16'h0000;
      srcB_out                                 <= 16'h0000;
      srcA_vector_out                          <= 128'h0;
      srcB_vector_out                          <= 128'h0;
      rs1_execute                              <= 5'd0;
      rs2_execute                              <= 5'd0;
      rd_execute                               <= 5'd0;
    end else begin
      wre_execute                              <= nop_mux_output_in[19];
      vector_wre_execute                       <= nop_mux_output_in[18];
      write_memory_enable_a_execute            <= nop_mux_output_in[17];
      write_memory_enable_b_execute            <= nop_mux_output_in[16];
      select_writeback_data_mux_execute        <= nop_mux_output_in[15:14];
      select_writeback_vector_data_mux_execute <= nop_mux_output_in[13:12];
      aluOp_execute                            <= nop_mux_output_in[11:7];
      aluVectorOp_execute                      <= nop_mux_output_in[6:2];
      load_instruction                         <= nop_mux_output_in[1];
      srcA_out                                 <= srcA_in;
      srcB_out                                 <= srcB_in;
      srcA_vector_out                          <= srcA_vector_in;
      srcB_vector_out                          <= srcB_vector_in;
      rs1_execute                              <= rs1_decode;
      rs2_execute                              <= rs2_decode;
      rd_execute                               <= rd_decode;
    end
  end

  // Scalar forwarding and scalar ALU; only the low byte feeds the ALU.
  always_comb begin
    alu_src_A          = fwd_mux(select_forward_mux_A, srcA_out, writeback_data, alu_result_memory);
    alu_src_B          = fwd_mux(select_forward_mux_B, srcB_out, writeback_data, alu_result_memory);
    alu_result_execute = alu8(aluOp_execute, alu_src_A[7:0], alu_src_B[7:0]);
  end

  // Vector ALU: sixteen independent byte lanes, no inter-lane carry.
  always_comb begin
    alu_vector_result_execute = 128'h0;
    for (int i = 0; i < 16; i++) begin
      alu_vector_result_execute[8*i +: 8] =
        alu8(aluVectorOp_execute, srcA_vector_out[8*i +: 8], srcB_vector_out[8*i +: 8]);
    end
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_decode_execute_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [19:0]  nop_mux_output_in;
  logic [15:0]  srcA_in, srcB_in;
  logic [127:0] srcA_vector_in, srcB_vector_in;
  logic [4:0]   rs1_decode, rs2_decode, rd_decode;
  logic [2:0]   select_forward_mux_A, select_forward_mux_B;
  logic [15:0]  writeback_data;
  logic [7:0]   alu_result_memory;
  logic         wre_execute, vector_wre_execute, write_memory_enable_a_execute;
  logic         write_memory_enable_b_execute, load_instruction;
  logic [1:0]   select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute;
  logic [4:0]   aluOp_execute, aluVectorOp_execute;
  logic [15:0]  srcA_out, srcB_out, alu_src_A, alu_src_B;
  logic [127:0] srcA_vector_out, srcB_vector_out;
  logic [4:0]   rs1_execute, rs2_execute, rd_execute;
  logic [7:0]   alu_result_execute;
  logic [127:0] alu_vector_result_execute;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [18:0]  ctrl;
    logic [15:0]  sa, sb, fa, fb;
    logic [127:0] va, vb, vres;
    logic [4:0]   rs1, rs2, rd;
    logic [7:0]   res;
  } exp_t;

  exp_t exp_q[$];

  decode_execute_stage dut (
    .clk(clk), .reset(reset),
    .nop_mux_output_in(nop_mux_output_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcA_vector_in(srcA_vector_in), .srcB_vector_in(srcB_vector_in),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
    .select_forward_mux_A(select_forward_mux_A), .select_forward_mux_B(select_forward_mux_B),
    .writeback_data(writeback_data), .alu_result_memory(alu_result_memory),
    .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
    .write_memory_enable_a_execute(write_memory_enable_a_execute),
    .write_memory_enable_b_execute(write_memory_enable_b_execute),
    .load_instruction(load_instruction),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .select_writeback_vector_data_mux_execute(select_writeback_vector_data_mux_execute),
    .aluOp_execute(aluOp_execute), .aluVectorOp_execute(aluVectorOp_execute),
    .srcA_out(srcA_out), .srcB_out(srcB_out),
    .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .srcA_vector_out(srcA_vector_out), .srcB_vector_out(srcB_vector_out),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .alu_result_execute(alu_result_execute),
    .alu_vector_result_execute(alu_vector_result_execute)
  );

  always #5 clk = ~clk;

  // Reference ALU written with plain integer arithmetic.
  function automatic int ref_alu(int op, int a, int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return (a * (2 ** (b % 8))) % 256;
      6:       return a / (2 ** (b % 8));
      7:       return (a * b) % 256;
      8:       return a;
      9:       return b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] ref_fwd(int sel, logic [15:0] regv, logic [15:0] wb, logic [7:0] mem);
    if (sel == 1) return wb;
    else if (sel == 2) return {8'h00, mem};
    else return regv;
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [18:0] ctrl_now();
    return {wre_execute, vector_wre_execute, write_memory_enable_a_execute,
            write_memory_enable_b_execute, select_writeback_data_mux_execute,
            select_writeback_vector_data_mux_execute, aluOp_execute,
            aluVectorOp_execute, load_instruction};
  endfunction

  // Monitor: every live cycle with a pending expectation presents one result.
  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl", {109'h0, ctrl_now()}, {109'h0, e.ctrl});
      check("srcA_out", {112'h0, srcA_out}, {112'h0, e.sa});
      check("srcB_out", {112'h0, srcB_out}, {112'h0, e.sb});
      check("vecA_out", srcA_vector_out, e.va);
      check("vecB_out", srcB_vector_out, e.vb);
      check("addrs", {113'h0, rs1_execute, rs2_execute, rd_execute}, {113'h0, e.rs1, e.rs2, e.rd});
      check("alu_src_A", {112'h0, alu_src_A}, {112'h0, e.fa});
      check("alu_src_B", {112'h0, alu_src_B}, {112'h0, e.fb});
      check("alu_result", {120'h0, alu_result_execute}, {120'h0, e.res});
      check("vec_result", alu_vector_result_execute, e.vres);
    end
  end

  // Drive decode inputs, wait for the capture edge, then apply forwarding and queue the expectation.
  task automatic issue(logic [19:0] cw, logic [15:0] sa, logic [15:0] sb,
                       logic [127:0] va, logic [127:0] vb,
                       logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                       logic [2:0] sela, logic [2:0] selb,
                       logic [15:0] wb, logic [7:0] mem);
    exp_t e;
    nop_mux_output_in = cw;
    srcA_in = sa; srcB_in = sb;
    srcA_vector_in = va; srcB_vector_in = vb;
    rs1_decode = rs1; rs2_decode = rs2; rd_decode = rd;
    @(posedge clk);
    #1;
    select_forward_mux_A = sela; select_forward_mux_B = selb;
    writeback_data = wb; alu_result_memory = mem;
    e.ctrl = cw[19:1];
    e.sa = sa; e.sb = sb; e.va = va; e.vb = vb;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.fa = ref_fwd(int'(sela), sa, wb, mem);
    e.fb = ref_fwd(int'(selb), sb, wb, mem);
    e.res = 8'(ref_alu(int'(cw[11:7]), int'(e.fa[7:0]), int'(e.fb[7:0])));
    e.vres = 128'h0;
    for (int i = 0; i < 16; i++) begin
      e.vres[8*i +: 8] = 8'(ref_alu(int'(cw[6:2]), int'(va[8*i +: 8]), int'(vb[8*i +: 8])));
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [4:0] pick_op();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(10, 31));
    else return 5'($urandom_range(0, 9));
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_all_zero(string tag);
    check({tag, "_ctrl"}, {109'h0, ctrl_now()}, 128'h0);
    check({tag, "_ops"}, {96'h0, srcA_out, srcB_out}, 128'h0);
    check({tag, "_vops"}, srcA_vector_out | srcB_vector_out, 128'h0);
    check({tag, "_addr"}, {113'h0, rs1_execute, rs2_execute, rd_execute}, 128'h0);
    check({tag, "_fwd"}, {96'h0, alu_src_A, alu_src_B}, 128'h0);
    check({tag, "_res"}, {120'h0, alu_result_execute}, 128'h0);
    check({tag, "_vres"}, alu_vector_result_execute, 128'h0);
  endtask

  initial begin
    logic [31:0]  r;
    logic [19:0]  cw;
    logic [127:0] ff_lanes, one_lanes;
    ff_lanes  = {16{8'hFF}};
    one_lanes = {16{8'h01}};

    // Reset held with nonzero inputs.
    reset = 1'b1;
    nop_mux_output_in = 20'hFFFFF;
    srcA_in = 16'h1234; srcB_in = 16'h5678;
    srcA_vector_in = ff_lanes; srcB_vector_in = one_lanes;
    rs1_decode = 5'd3; rs2_decode = 5'd4; rd_decode = 5'd5;
    select_forward_mux_A = 3'd0; select_forward_mux_B = 3'd0;
    writeback_data = 16'hAAAA; alu_result_memory = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_all_zero("after_release");

    // Capture and scalar ADD with wrap.
    issue({1'b1, 19'h0}, 16'h00F0, 16'h0020, 128'h0, 128'h0, 5'd1, 5'd2, 5'd3,
          3'd0, 3'd0, 16'h0, 8'h0);

    // Forwarding on SUB with registered A=5, B=3.
    cw = 20'h0;
    cw[11:7] = 5'd1;
    issue(cw, 16'h0005, 16'h0003, 128'h0, 128'h0, 5'd1, 5'd2, 5'd3, 3'd1, 3'd0, 16'h0009, 8'h00);
    issue(cw, 16'h0005, 16'h0003, 128'h0, 128'h0, 5'd1, 5'd2, 5'd3, 3'd1, 3'd2, 16'h0009, 8'h01);
    issue(cw, 16'h0005, 16'h0003, 128'h0, 128'h0, 5'd1, 5'd2, 5'd3, 3'd5, 3'd5, 16'h0009, 8'h01);

    // Vector ADD without inter-lane carry, then vector MUL.
    cw = 20'h0;
    cw[18] = 1'b1;
    issue(cw, 16'h0, 16'h0, ff_lanes, one_lanes, 5'd7, 5'd8, 5'd9, 3'd0, 3'd0, 16'h0, 8'h0);
    cw[6:2] = 5'd7;
    issue(cw, 16'h0, 16'h0, ff_lanes, one_lanes, 5'd7, 5'd8, 5'd9, 3'd0, 3'd0, 16'h0, 8'h0);

    // Bubble: operands and addresses still captured.
    issue(20'h0, 16'hBEEF, 16'hCAFE, rand128(), rand128(), 5'd10, 5'd11, 5'd12,
          3'd0, 3'd0, 16'h0, 8'h0);

    // Async reset pulse between edges with a live control word registered.
    issue(20'hFFFFE, 16'h00A5, 16'h005A, ff_lanes, ff_lanes, 5'd21, 5'd22, 5'd23,
          3'd0, 3'd0, 16'h0, 8'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    issue(20'h8F0AC, 16'h0011, 16'h0022, rand128(), rand128(), 5'd1, 5'd30, 5'd31,
          3'd0, 3'd0, 16'h0, 8'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      cw = r[19:0];
      cw[11:7] = pick_op();
      cw[6:2]  = pick_op();
      r = $urandom();
      issue(cw, r[15:0], r[31:16], rand128(), rand128(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom()), 8'($urandom()));
    end

    @(negedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/decode_execute_stage.md
# decode_execute_stage

Decode/Execute pipeline boundary of the scalar+vector CPU. It holds one 20-bit decoded control word, the scalar and vector register-file operands, and the register addresses. It applies operand forwarding to the scalar path. It drives an 8-bit scalar ALU and a 128-bit (16×8-bit lane) vector ALU combinationally from the registered values. It sits between the decode logic (control unit + NOP mux, register files) and the Execute/Memory register.

## Interface
Parameters: none. Widths are fixed.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears every register.
- nop_mux_output_in  in  20  control word; all-zero means NOP/bubble.
- srcA_in, srcB_in  in  16  scalar operands read in decode.
- srcA_vector_in, srcB_vector_in  in  128  vector operands read in decode.
- rs1_decode, rs2_decode, rd_decode  in  5  register addresses.
- select_forward_mux_A, select_forward_mux_B  in  3  forwarding selects from the forwarding unit.
- writeback_data  in  16  forwarded value from the writeback stage.
- alu_result_memory  in  8  forwarded ALU result from the memory stage.
- wre_execute, vector_wre_execute, write_memory_enable_a_execute, write_memory_enable_b_execute, load_instruction  out  1  registered control bits.
- select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute  out  2  registered.
- aluOp_execute, aluVectorOp_execute  out  5  registered.
- srcA_out, srcB_out  out  16  registered scalar operands, before forwarding.
- alu_src_A, alu_src_B  out  16  forwarded scalar operands.
- srcA_vector_out, srcB_vector_out  out  128  registered vector operands.
- rs1_execute, rs2_execute, rd_execute  out  5  registered addresses.
- alu_result_execute  out  8  scalar ALU result.
- alu_vector_result_execute  out  128  vector ALU result.

## Operation
Control word fields:
- [19] wre
- [18] vector_wre
- [17] write_memory_enable_a
- [16] write_memory_enable_b
- [15:14] select_writeback_data_mux
- [13:12] select_writeback_vector_data_mux
- [11:7] aluOp
- [6:2] aluVectorOp
- [1] load_instruction
- [0] reserved, ignored, not stored

Forwarding muxes, A and B identical:
- sel 0 → srcA_out / srcB_out.
- sel 1 → writeback_data.
- sel 2 → {8'h00, alu_result_memory}.
- sel 3–7 → same as sel 0.

Scalar ALU:
- Operands are alu_src_A[7:0] and alu_src_B[7:0]. Result is 8 bits; overflow and carry are discarded.
- 0 ADD A+B mod 256.
- 1 SUB A−B mod 256.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SLL A<<B[2:0].
- 6 SRL A>>B[2:0], logical.
- 7 MUL, low 8 bits of A*B.
- 8 pass A.
- 9 pass B.
- 10–31 → 0.

Vector ALU:
- Lane i = bits [8i+7:8i], i = 0..15. Lane 0 is the least-significant byte.
- Same op encoding as the scalar ALU, applied independently per lane on srcA_vector_out and srcB_vector_out.
- Shift amount is that lane's B[2:0].
- No carry propagates between lanes.
- Codes 10–31 → all-zero.

Vector operands are not forwarded.

## Timing
- All registered outputs update on rising clk: next value = the corresponding input (control fields sliced from nop_mux_output_in). Latency is one cycle.
- No enable, no stall input. A bubble is a zero control word, which registers as wre=0, vector_wre=0, both memory write enables 0, and aluOp/aluVectorOp=0.
- Bubble operands and addresses still register normally.
- Reset asserted (asynchronous, at any time including mid-pipeline) → every registered output becomes 0 immediately. Resulting values:
  - alu_src_A and alu_src_B = 0 when their selects are 0/3–7.
  - alu_result_execute = 0 (ADD 0+0).
  - alu_vector_result_execute = 0.
- Reset deasserted → the first capture happens on the next rising edge.
- alu_src_*, alu_result_execute and alu_vector_result_execute are purely combinational from registered values and live forwarding inputs. They are valid within the same cycle and must settle before the next rising edge.
- Forwarding selects and forwarded data are not registered.

## Test plan
- Reset: hold reset with nonzero inputs, then release → all registered outputs 0; alu_result_execute=0 and alu_vector_result_execute=0 while reset is held.
- Capture/ADD: control word with wre=1 and aluOp=0, srcA_in=16'h00F0, srcB_in=16'h0020, fwd selects 0 → after one edge wre_execute=1 and alu_result_execute=8'h10 (wrap).
- Forwarding: registered srcA=8'h05 and B=8'h03 with aluOp=1. sel A=1 with writeback_data=16'h0009 gives result 8'h06. sel B=2 with alu_result_memory=8'h01 (sel A=1 held) gives 8'h08. sel 5 gives the registered value.
- Vector ADD: aluVectorOp=0, A lanes all 8'hFF, B lanes all 8'h01 → result 128'h0 with no inter-lane carry. Same operands with aluVectorOp=7 → all lanes 8'hFF.
- Bubble: nop_mux_output_in=0 → wre_execute, vector_wre_execute and both memory write enables 0 after the edge. Operands and rd_execute still track their inputs.
- Async reset mid-stream: pulse reset between edges while a nonzero control word is registered → outputs drop to 0 before the next edge. On the next edge after release they capture the current inputs.
